// File: rtl/hilbert_pkg.sv
// Shared types, constants and the saturating adder for the Hilbert SSB controller.
package hilbert_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_TAPS       = 55;
    localparam int SAT_W          = 64;

    localparam logic signed [DATA_WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [DATA_WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // a +/- b, evaluated one bit wider than the operands and clamped to a signed
    // range of 'width' bits; operands arrive sign-extended to SAT_W bits.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input logic                    sub,
        input int                      width
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = sub ? ({a[SAT_W-1], a} - {b[SAT_W-1], b})
                  : ({a[SAT_W-1], a} + {b[SAT_W-1], b});
        hi = '0;
        hi[width-1] = 1'b1;
        hi = hi - {{SAT_W{1'b0}}, 1'b1};
        lo = ~hi;
        if (sum > hi)
            return hi[SAT_W-1:0];
        else if (sum < lo)
            return lo[SAT_W-1:0];
        else
            return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/hilbert_ctrl_fifo.sv
// Small synchronous FIFO with flush; full is judged before any same-cycle pop.
module hilbert_ctrl_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_wr   = wr_en & ~full & ~flush;
    assign do_rd   = rd_en & (count != '0) & ~flush;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    // NOTE: storage is left unreset; count gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hilbert_ctrl.sv
// Sequencer and SSB combiner in front of the single-MAC Hilbert engine.
// Optional engine watchdog and eng_timeout port: define HILBERT_CTRL_WATCHDOG_EN.
module hilbert_ctrl
    import hilbert_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int WARMUP     = NUM_TAPS,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_i,
    input  logic signed [DATA_WIDTH-1:0] in_q,
    input  logic                         flush,
    input  logic                         sideband,
    output logic                         eng_valid,
    output logic signed [DATA_WIDTH-1:0] eng_i,
    output logic signed [DATA_WIDTH-1:0] eng_q,
    input  logic                         eng_res_valid,
    input  logic signed [DATA_WIDTH-1:0] eng_i_res,
    input  logic signed [DATA_WIDTH-1:0] eng_q_res,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         busy,
    output logic                         overrun,
`ifdef HILBERT_CTRL_WATCHDOG_EN
    output logic                         eng_timeout,
`endif
    output logic [CNT_WIDTH-1:0]         overrun_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    state_t                  state_next;
    logic [2*DATA_WIDTH-1:0] head;
    logic                    full;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic                    pop;
    logic                    drop;
    logic                    wd_fire;
    logic [7:0]              warm_cnt;
    logic                    discard;
    logic                    res_use;

    assign fifo_empty = (fifo_count == '0);
    assign drop       = in_valid & ~flush & full;
    // A result is dropped if a flush hit its WAIT window, including the arrival cycle itself.
    assign res_use    = eng_res_valid & ~discard & ~flush & (warm_cnt == 8'd0);

    hilbert_ctrl_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (in_valid),
        .wr_data ({in_i, in_q}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .count   (fifo_count)
    );

`ifdef HILBERT_CTRL_WATCHDOG_EN
    logic [7:0] wd_timer;

    // Fires in the 255th consecutive WAIT cycle without a result.
    assign wd_fire = (state == ST_WAIT) & ~eng_res_valid & (wd_timer == 8'd254);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_timer    <= 8'd0;
            eng_timeout <= 1'b0;
        end else begin
            wd_timer <= (state == ST_WAIT) ? wd_timer + 8'd1 : 8'd0;
            if (flush)
                eng_timeout <= 1'b0;
            else if (wd_fire)
                eng_timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal driven here is defaulted first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop        = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_res_valid || wd_fire) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: all registered state below uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_valid   <= 1'b0;
            eng_i       <= '0;
            eng_q       <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
            warm_cnt    <= 8'(WARMUP);
            discard     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            eng_valid <= pop;
            if (pop) {eng_i, eng_q} <= head;

            // busy covers the engine's compute window, from the cycle after the strobe to the result.
            if (eng_valid)
                busy <= 1'b1;
            else if (state == ST_WAIT && state_next == ST_IDLE)
                busy <= 1'b0;

            if (flush) begin
                overrun     <= 1'b0;
                overrun_cnt <= '0;
            end else if (drop) begin
                overrun <= 1'b1;
                if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + CNT_WIDTH'(1);
            end

            if (eng_res_valid || wd_fire)
                discard <= 1'b0;
            else if (flush && state == ST_WAIT)
                discard <= 1'b1;

            if (flush || wd_fire)
                warm_cnt <= 8'(WARMUP);
            else if (eng_res_valid && !discard && warm_cnt != 8'd0)
                warm_cnt <= warm_cnt - 8'd1;

            out_valid <= res_use;
            if (res_use)
                out_data <= DATA_WIDTH'(sat_add(SAT_W'(eng_i_res), SAT_W'(eng_q_res),
                                                sideband, DATA_WIDTH));
        end
    end

endmodule

// File: tb/tb_hilbert_ctrl.sv
// Randomised bench for hilbert_ctrl against a queue-based reference model and engine stub.
module tb_hilbert_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int WARM  = 55;
    localparam int CW    = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_i = '0;
    logic signed [DW-1:0] in_q = '0;
    logic                 flush = 1'b0;
    logic                 sideband = 1'b0;
    logic                 eng_valid;
    logic signed [DW-1:0] eng_i;
    logic signed [DW-1:0] eng_q;
    logic                 eng_res_valid = 1'b0;
    logic signed [DW-1:0] eng_i_res = '0;
    logic signed [DW-1:0] eng_q_res = '0;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 busy;
    logic                 overrun;
    logic [CW-1:0]        overrun_cnt;
`ifdef HILBERT_CTRL_WATCHDOG_EN
    logic                 eng_timeout;
`endif

    always #5 clk = ~clk;

    hilbert_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .WARMUP     (WARM),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_i          (in_i),
        .in_q          (in_q),
        .flush         (flush),
        .sideband      (sideband),
        .eng_valid     (eng_valid),
        .eng_i         (eng_i),
        .eng_q         (eng_q),
        .eng_res_valid (eng_res_valid),
        .eng_i_res     (eng_i_res),
        .eng_q_res     (eng_q_res),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .busy          (busy),
        .overrun       (overrun),
`ifdef HILBERT_CTRL_WATCHDOG_EN
        .eng_timeout   (eng_timeout),
`endif
        .overrun_cnt   (overrun_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } smp_t;

    // Reference model state
    smp_t                 fifo_q[$];
    bit                   outstanding = 0;
    bit                   discard = 0;
    int                   warm = WARM;
    bit                   ovr = 0;
    int                   ovr_cnt = 0;
    bit                   exp_ov = 0;
    logic signed [63:0]   exp_od = '0;
    int                   n_issue = 0;
    int                   n_out = 0;
    logic signed [DW-1:0] last_out = '0;
    int                   cyc = 0;
    int                   issue_cyc = 0;
    bit                   prev_to = 0;

    // Engine stub controls
    int                   eng_timer = 0;
    bit                   eng_alive = 1;
    bit                   rand_lat = 0;
    bit                   dir_en = 0;
    logic signed [DW-1:0] dir_i = '0;
    logic signed [DW-1:0] dir_q = '0;
    bit                   sb = 0;

    function automatic longint ref_ssb(input longint a, input longint b, input bit lsb);
        longint s;
        s = lsb ? a - b : a + b;
        if (s > longint'(hilbert_pkg::SAT_MAX)) s = longint'(hilbert_pkg::SAT_MAX);
        if (s < longint'(hilbert_pkg::SAT_MIN)) s = longint'(hilbert_pkg::SAT_MIN);
        return s;
    endfunction

    task automatic model();
        smp_t s;
`ifdef HILBERT_CTRL_WATCHDOG_EN
        if (eng_timeout && !prev_to) begin
            outstanding = 0;
            discard     = 0;
            warm        = WARM;
        end
        prev_to = eng_timeout;
`endif
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) check("out_data", 64'(out_data), exp_od);
        if (out_valid) begin
            n_out++;
            last_out = out_data;
        end
        check("overrun", 64'(overrun), 64'(ovr));
        check("overrun_cnt", 64'(overrun_cnt), 64'(ovr_cnt));
        check("busy", 64'(busy), 64'(outstanding));
        exp_ov = 0;

        if (eng_valid) begin
            n_issue++;
            issue_cyc = cyc;
            check("issue_while_busy", 64'(outstanding), 64'(0));
            check("issue_nonempty", 64'(fifo_q.size() != 0), 64'(1));
            if (fifo_q.size() != 0) begin
                s = fifo_q.pop_front();
                check("eng_i", 64'(eng_i), 64'($signed(s.i)));
                check("eng_q", 64'(eng_q), 64'($signed(s.q)));
            end
            outstanding = 1;
            eng_timer   = rand_lat ? int'($urandom_range(30, 2)) : 112;
        end

        if (eng_res_valid) begin
            outstanding = 0;
            if (discard || flush) discard = 0;
            else if (warm > 0) warm--;
            else begin
                exp_ov = 1;
                exp_od = ref_ssb(longint'(eng_i_res), longint'(eng_q_res), sideband);
            end
        end

        if (flush) begin
            fifo_q.delete();
            warm    = WARM;
            ovr     = 0;
            ovr_cnt = 0;
            if (outstanding) discard = 1;
        end else if (in_valid) begin
            if (fifo_q.size() < DEPTH) begin
                s.i = in_i;
                s.q = in_q;
                fifo_q.push_back(s);
            end else begin
                ovr = 1;
                if (ovr_cnt < 65535) ovr_cnt++;
            end
        end
    endtask

    task automatic step(input bit iv, input bit fl);
        @(posedge clk);
        #1;
        cyc++;
        in_valid = iv;
        flush    = fl;
        sideband = sb;
        if (iv) begin
            in_i = $urandom;
            in_q = $urandom;
        end
        eng_res_valid = 1'b0;
        if (eng_timer > 0) begin
            eng_timer--;
            if (eng_timer == 0 && eng_alive) begin
                eng_res_valid = 1'b1;
                eng_i_res = dir_en ? dir_i : $urandom;
                eng_q_res = dir_en ? dir_q : $urandom;
            end
        end
        @(negedge clk);
        model();
    endtask

    task automatic send_dir(input string tag, input logic signed [DW-1:0] i, input logic signed [DW-1:0] q,
                            input bit sbv, input logic signed [63:0] expv);
        int o0;
        dir_i = i;
        dir_q = q;
        sb    = sbv;
        o0    = n_out;
        step(1, 0);
        repeat (130) step(0, 0);
        check({tag, "_count"}, 64'(n_out - o0), 64'(1));
        check(tag, 64'(last_out), expv);
    endtask

    initial begin
        int i0;
        int o0;
        bit iv;
        bit fl;

        repeat (3) @(negedge clk);
        check("rst_eng_valid", 64'(eng_valid), 64'(0));
        check("rst_eng_i", 64'(eng_i), 64'(0));
        check("rst_eng_q", 64'(eng_q), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_overrun_cnt", 64'(overrun_cnt), 64'(0));
`ifdef HILBERT_CTRL_WATCHDOG_EN
        check("rst_eng_timeout", 64'(eng_timeout), 64'(0));
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Warm-up: 60 widely spaced samples, first 55 results suppressed
        for (int k = 0; k < 60; k++) begin
            step(1, 0);
            repeat (199) step(0, 0);
        end
        check("warm_issued", 64'(n_issue), 64'(60));
        check("warm_outputs", 64'(n_out), 64'(5));
        check("warm_overrun", 64'(overrun), 64'(0));

        // Burst of 6 while the engine is busy
        i0 = n_issue;
        step(1, 0);
        repeat (3) step(0, 0);
        repeat (6) step(1, 0);
        step(0, 0);
        check("burst_overrun", 64'(overrun), 64'(1));
        check("burst_overrun_cnt", 64'(overrun_cnt), 64'(2));
        repeat (650) step(0, 0);
        check("burst_issued", 64'(n_issue - i0), 64'(5));

        // Directed saturation and sideband cases
        dir_en = 1;
        send_dir("sat_usb", 32'sh7FFF0000, 32'sh7FFF0000, 0, 64'sh7FFFFFFF);
        send_dir("sat_lsb", 32'sh7FFF0000, 32'sh7FFF0000, 1, 64'sd0);
        send_dir("neg_usb", -32'sd5, 32'sd3, 0, -64'sd2);
        send_dir("neg_lsb", -32'sd5, 32'sd3, 1, -64'sd8);
        send_dir("sat_min", 32'sh80000000, 32'sd1, 1, -64'sh80000000);
        dir_en = 0;
        sb     = 0;

        // Flush mid-WAIT with three queued samples
        step(1, 0);
        repeat (5) step(0, 0);
        repeat (3) step(1, 0);
        repeat (10) step(0, 0);
        i0 = n_issue;
        o0 = n_out;
        step(0, 1);
        repeat (150) step(0, 0);
        check("flush_no_issue", 64'(n_issue - i0), 64'(0));
        check("flush_overrun_cnt", 64'(overrun_cnt), 64'(0));
        check("flush_discard", 64'(n_out - o0), 64'(0));
        for (int k = 0; k < 56; k++) begin
            step(1, 0);
            repeat (119) step(0, 0);
        end
        check("flush_rewarm_out", 64'(n_out - o0), 64'(1));
        check("flush_rewarm_issued", 64'(n_issue - i0), 64'(56));

        // Random traffic with short engine latency
        rand_lat = 1;
        repeat (3000) begin
            iv = ($urandom % 6) == 0;
            fl = ($urandom % 400) == 0;
            sb = 1'($urandom % 2);
            step(iv, fl);
        end
        repeat (200) step(0, 0);
        rand_lat = 0;

`ifdef HILBERT_CTRL_WATCHDOG_EN
        // Engine never answers: watchdog returns the FSM to IDLE
        eng_alive = 0;
        i0 = n_issue;
        step(1, 0);
        for (int k = 0; k < 400 && !eng_timeout; k++) step(0, 0);
        check("wd_timeout", 64'(eng_timeout), 64'(1));
        check("wd_wait_cycles", 64'(cyc - issue_cyc), 64'(255));
        eng_alive = 1;
        eng_timer = 0;
        step(1, 0);
        repeat (130) step(0, 0);
        check("wd_next_issue", 64'(n_issue - i0), 64'(2));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilbert_ctrl.md
Name: hilbert_ctrl

Overview:
Sequencing controller in front of the single-MAC Hilbert engine in the SDR receive chain. A small input FIFO absorbs decimator samples that arrive while the engine is computing, and the controller issues exactly one sample per engine idle window. It suppresses results until the 55-tap delay line is primed after reset or flush. It combines engine I/Q results into a saturated USB/LSB audio sample.

Parameters:
DATA_WIDTH, 32, I/Q sample width (signed)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)
WARMUP, 55, engine results discarded after reset/flush (1..255)
CNT_WIDTH, 16, overrun counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle strobe: new sample on in_i/in_q
in_i  in  DATA_WIDTH  signed I from decimator
in_q  in  DATA_WIDTH  signed Q from decimator
flush  in  1  synchronous flush request (level, sampled each cycle)
sideband  in  1  0=USB (I+Q), 1=LSB (I-Q)
eng_valid  out  1  one-cycle start strobe to engine
eng_i  out  DATA_WIDTH  I sample to engine
eng_q  out  DATA_WIDTH  Q sample to engine
eng_res_valid  in  1  engine result strobe
eng_i_res  in  DATA_WIDTH  delayed I from engine
eng_q_res  in  DATA_WIDTH  Hilbert-shifted Q from engine
out_valid  out  1  one-cycle strobe: demodulated sample valid
out_data  out  DATA_WIDTH  signed SSB sample
busy  out  1  engine has an outstanding sample
overrun  out  1  sticky: a sample was dropped since last flush/reset
overrun_cnt  out  CNT_WIDTH  dropped-sample count, saturating

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state IDLE, warm-up count = WARMUP. All outputs 0.
- FIFO write: in_valid with FIFO not full, judged before any same-cycle pop, so the sample is stored. in_valid with FIFO full: sample dropped, overrun set, overrun_cnt incremented and saturated at all-ones.
- FSM IDLE: if FIFO non-empty and flush=0, pop the head, drive eng_i/eng_q, pulse eng_valid for 1 cycle, go to WAIT. eng_valid is registered and asserts the cycle after the pop decision.
- FSM WAIT: busy=1. On eng_res_valid go to IDLE. The earliest next eng_valid is 2 cycles after eng_res_valid, which guarantees the engine has returned to idle.
- eng_valid is never asserted while busy=1.
- eng_i/eng_q hold their last issued value between strobes.
- Result path, on eng_res_valid:
  - If warm-up count > 0: decrement it; out_valid stays 0.
  - Otherwise: out_data = sat(eng_i_res + eng_q_res) when sideband=0, sat(eng_i_res - eng_q_res) when sideband=1.
  - Sum is computed at DATA_WIDTH+1 bits and saturated to the signed DATA_WIDTH range. out_valid pulses 1 cycle later (1-cycle latency).
- sideband is sampled in the eng_res_valid cycle. Changing it never triggers warm-up.
- flush=1: FIFO cleared the same cycle, warm-up reloaded to WARMUP, overrun and overrun_cnt cleared, in_valid ignored.
  - If in WAIT, stay in WAIT until eng_res_valid, then discard that result (no warm-up decrement).
  - No issue occurs while flush=1.
- Simultaneous in_valid and pop on a full FIFO: the write is dropped (full is judged pre-pop).
- Pointers wrap modulo FIFO_DEPTH; the count is a separate log2(FIFO_DEPTH)+1-bit register.

Optional Feature:
HILBERT_CTRL_WATCHDOG_EN:
- Defined: an 8-bit timer runs in WAIT. If 255 cycles pass with no eng_res_valid, the FSM returns to IDLE, the in-flight sample is lost, warm-up is reloaded, and sticky output eng_timeout is set; eng_timeout is cleared by flush or reset. The eng_timeout port exists only when the macro is defined.
- Undefined: WAIT waits indefinitely; no timer and no port.

Decomposition:
- Package hilbert_pkg: DATA_WIDTH default, NUM_TAPS=55, state encoding (IDLE, WAIT), the saturation-limit constants, and a function sat_add for signed saturating add/sub.
- Natural sub-module hilbert_ctrl_fifo: synchronous FIFO with full/empty/count and flush. The FSM, warm-up counter and SSB combiner stay in hilbert_ctrl.

Test Plan:
- Reset, then 60 samples spaced 200 cycles apart against an engine model (112-cycle latency) -> exactly 60 eng_valid, first 55 results suppressed, 5 out_valid pulses, overrun=0.
- Burst of 6 in_valid on consecutive cycles with the engine busy -> 4 stored, 2 dropped, overrun=1, overrun_cnt=2, 4 eng_valid issued in order.
- After warm-up, engine returns I=0x7FFF0000 and Q=0x7FFF0000 with sideband=0 -> out_data=0x7FFFFFFF (saturated). Same values with sideband=1 -> out_data=0.
- After warm-up, result I=-5, Q=3: sideband=0 -> out_data=-2; sideband=1 -> out_data=-8; each 1 cycle after eng_res_valid.
- Assert flush for 1 cycle mid-WAIT with 3 FIFO entries -> FIFO empty, that result discarded, next 55 results suppressed, overrun_cnt=0.
- With HILBERT_CTRL_WATCHDOG_EN defined, the engine never responds -> after 255 WAIT cycles, eng_timeout=1 and state=IDLE; the next sample issues normally.
